// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer holding HI/LO, with busy tracking and D-stage stall request
//   clk        system clock
//   reset      asynchronous active-low reset
//   start      E-stage MDU instruction valid
//   op         0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6/7=no-op
//   a, b       rs / rt operands
//   d_use_mdu  D-stage instruction reads HI/LO or uses the MDU
//   busy       multi-cycle operation in flight
//   stall_req  hold D-stage while the MDU is occupied or being issued
//   hi, lo     architectural HI/LO registers
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_use_mdu,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, state_d;
  logic [3:0]  count, count_d;
  logic [31:0] res_hi, res_lo;
  logic        res_keep;
  logic        idle, issue, done;
  logic [63:0] prod_s, prod_u;
  logic [31:0] bd, mag_a, mag_b, div_n, div_d, q, r, q_s, r_s;
  logic [31:0] calc_hi, calc_lo;
  assign idle  = state == IDLE;
  assign issue = start & idle & ~op[2];
  assign done  = state == RUN && count == 4'd1;
  assign busy  = state == RUN;
  // Issue cycle counts too, so mfhi/mflo in D cannot slip past before busy rises.
  assign stall_req = d_use_mdu & (busy | (start & ~op[2]));
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};
  // Divide-by-zero never commits, so substitute 1 to keep the divider free of X.
  assign bd    = b == 32'd0 ? 32'd1 : b;
  assign mag_a = a[31] ? -a : a;
  assign mag_b = bd[31] ? -bd : bd;
  // One shared divider: unsigned operands for divu, magnitudes for div.
  assign div_n = op[0] ? a : mag_a;
  assign div_d = op[0] ? bd : mag_b;
  assign q     = div_n / div_d;
  assign r     = div_n % div_d;
  assign q_s   = (a[31] ^ bd[31]) ? -q : q;
  assign r_s   = a[31] ? -r : r;
  assign calc_hi = op[1] ? (op[0] ? r : r_s) : (op[0] ? prod_u[63:32] : prod_s[63:32]);
  assign calc_lo = op[1] ? (op[0] ? q : q_s) : (op[0] ? prod_u[31:0] : prod_s[31:0]);
  always_comb begin
    state_d = state;
    count_d = count;
    if (issue) begin
      state_d = RUN;
      count_d = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (state == RUN) begin
      count_d = count - 4'd1;
      state_d = count == 4'd1 ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
      res_keep <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
      if (issue) begin
        res_hi   <= calc_hi;
        res_lo   <= calc_lo;
        res_keep <= op[1] & (b == 32'd0);
      end
      if (done && !res_keep) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (start && idle && op == 3'd4) hi <= a;
      if (start && idle && op == 3'd5) lo <= a;
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl with a cycle-level reference model and random stimulus
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        d_use_mdu;
  logic        busy, stall_req;
  logic [31:0] hi, lo;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;
  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          mcnt;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_use_mdu(d_use_mdu), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // Architectural result straight from the ISA rules; divide by zero leaves HI/LO as they were.
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] ch, input logic [31:0] cl);
    longint sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (o >= 3'd2 && y == 32'd0) return {ch, cl};
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return 64'(ux * uy);
      3'd2: begin
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= '0;
      m_lo <= '0;
      mcnt <= 0;
      exp_q.delete();
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (start && op <= 3'd3) begin
      logic [63:0] r;
      r = ref_res(op, a, b, m_hi, m_lo);
      p_hi <= r[63:32];
      p_lo <= r[31:0];
      mcnt <= op >= 3'd2 ? DC : MC;
      exp_q.push_back('{hi: r[63:32], lo: r[31:0], len: (op >= 3'd2 ? DC : MC)});
    end else if (start && op == 3'd4) begin
      m_hi <= a;
    end else if (start && op == 3'd5) begin
      m_lo <= a;
    end
  end
  logic prev_busy = 1'b0;
  int   run = 0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
      run = 0;
      chk("reset_busy", {31'd0, busy}, 32'd0);
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, mcnt != 0});
      chk("stall_req", {31'd0, stall_req}, {31'd0, d_use_mdu & ((mcnt != 0) | (start & (op <= 3'd3)))});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      if (busy) run++;
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: busy fell with no expected result queued");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_hi", hi, e.hi);
          chk("sb_lo", lo, e.lo);
          chk("sb_busy_len", run, e.len);
        end
        run = 0;
      end
      prev_busy = busy;
    end
  end
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 40) begin
      errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask
  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    reset = 1'b0;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    d_use_mdu = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    d_use_mdu = 1'b1;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    d_use_mdu = 1'b0;
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    issue(3'd3, 32'd7, 32'd2);
    wait_idle();
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("ovf_hi", hi, 32'd0);
    chk("ovf_lo", lo, 32'h8000_0000);
    issue(3'd4, 32'h11, 32'd0);
    issue(3'd5, 32'h22, 32'd0);
    issue(3'd3, 32'd5, 32'd0);
    wait_idle();
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo", lo, 32'h22);
    issue(3'd5, 32'h1234_5678, 32'd0);
    chk("mtlo_hi", hi, 32'hDEAD_BEEF);
    chk("mtlo_lo", lo, 32'h1234_5678);
    d_use_mdu = 1'b1;
    issue(3'd0, 32'd7, 32'd6);
    @(posedge clk);
    #1 issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd4, 32'hBAD0_BAD0, 32'd0);
    wait_idle();
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd42);
    d_use_mdu = 1'b0;
    issue(3'd4, 32'h5555_AAAA, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (15) @(posedge clk);
    #1 chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);
    for (int i = 0; i < 1500; i++) begin
      d_use_mdu = 1'($urandom);
      start = ($urandom % 3) == 0;
      op = 3'($urandom);
      a = pick();
      b = pick();
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1 chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer for the E-stage multiply/divide unit of the pipelined CPU.
- Accepts MDU instructions (mult, multu, div, divu, mthi, mtlo) and holds HI/LO.
- Models multi-cycle latency with a busy counter.
- Raises a stall request to the hazard unit when a D-stage instruction needs the MDU while it is occupied.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  E-stage MDU instruction valid this cycle
op  input  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo, 6/7 reserved (no-op)
a  input  32  rs operand (forwarded)
b  input  32  rt operand (forwarded)
d_use_mdu  input  1  D-stage instruction is an MDU op or mfhi/mflo
busy  output  1  multi-cycle operation in flight
stall_req  output  1  = d_use_mdu & (busy | (start & op<=3))
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset==0, any time, asynchronous): state IDLE, count=0, busy=0, hi=0, lo=0; pending result discarded.
- States: IDLE, RUN.
- IDLE + start + op in {0..3}:
  - At edge k, compute the result from a/b and hold it in internal res_hi/res_lo.
  - Load count with MULT_CYCLES or DIV_CYCLES and go to RUN.
- RUN behaviour:
  - busy=1 for exactly N cycles after edge k, i.e. edges k+1..k+N see busy=1.
  - count decrements each edge.
  - At the edge where count goes 1->0: hi/lo <= res_hi/res_lo and state -> IDLE.
  - busy falls in the same cycle hi/lo become visible.
- IDLE + start + op=4/5: hi<=a (mthi) or lo<=a (mtlo) at that edge; no busy; the other register is unchanged.
- start while RUN: ignored entirely; hi/lo/res/count unaffected. The hazard unit guarantees no MDU op issues while busy.
- op 6/7 with start: no effect.
- mult: {hi,lo} = signed a*b, 64-bit. multu: same, unsigned.
- div: lo = signed a/b truncated toward zero; hi = remainder with the sign of a. divu: unsigned.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- Divide by zero (b==0, div or divu):
  - Full DIV_CYCLES busy period still runs.
  - At completion hi/lo keep their previous values; no exception is raised.
- stall_req is purely combinational from current inputs/state.
  - It includes the issue cycle (start & op<=3) so that mfhi/mflo in D cannot pass before busy rises.
- No flush input: an issued operation always completes unless reset asserts.

Test Plan:
- Reset: drive reset=0 mid-RUN (after 3 cycles of a div) -> busy=0, hi=lo=0 immediately; after release, IDLE with no late writeback.
- mult a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 -> lo=3, hi=1.
- Edge division:
  - 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0.
  - divu with b=0 after preloading hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo remain 0x11/0x22.
- mthi a=0xDEADBEEF then mtlo a=0x12345678 on consecutive cycles -> hi/lo updated on the next edges, busy never asserts. Second start of a mult while busy -> ignored, results match the first op only.
- stall_req:
  - d_use_mdu=1 with start & op=0 -> stall_req=1 in the issue cycle and all 5 busy cycles, 0 in the cycle after busy falls.
  - d_use_mdu=0 -> stall_req=0 throughout.
